rv32i_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I datapath (register file, PC register, ALU). It fetches an instruction over a req/ack instruction-memory handshake, then decodes it. It then drives the datapath select and enable signals through EXEC, MEM and WB states, and retires one instruction at a time. It owns the next-PC decision (`jump`), register-file write enable, ALU opcode and immediate generation, and a retired-instruction counter.

---
 rtl/rv32i_ctrl_if.sv | 28 ++
 rtl/rv32i_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_rv32i_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the RV32I control
// sequencer (master) and the memory subsystem (slave).
interface rv32i_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req,
    input  imem_ack,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );
endinterface

// File: rtl/rv32i_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory and
// write-back stepping with immediate generation and a retired counter.
module rv32i_ctrl (
  input  logic                clk,
  input  logic                rst,
  rv32i_ctrl_if.master        mem,
  input  logic                br_cond,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  output logic [4:0]          rd_addr,
  output logic [31:0]         imm,
  output logic [3:0]          alu_op,
  output logic                alu_src_a,
  output logic                alu_src_b,
  output logic [1:0]          wb_sel,
  output logic                rf_wr_en,
  output logic                pc_we,
  output logic                jump,
  output logic                illegal,
  output logic [31:0]         retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ir;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;

  assign opcode   = ir[6:0];
  assign funct3   = ir[14:12];
  assign funct7_5 = ir[30];
  assign rd_addr  = ir[11:7];
  assign rs1_addr = ir[19:15];
  assign rs2_addr = ir[24:20];

  logic is_op, is_op_imm, is_load, is_store, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc;
  logic legal, is_mem_access, writes_rd;

  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);

  assign legal = is_op | is_op_imm | is_load | is_store | is_branch |
                 is_jal | is_jalr | is_lui | is_auipc;
  assign is_mem_access = is_load | is_store;
  assign writes_rd = is_op | is_op_imm | is_load | is_jal | is_jalr |
                     is_lui | is_auipc;

  // Shared funct3 decode; only the register form may turn ADD into SUB.
  function automatic logic [3:0] funct_to_alu(input logic [2:0] f3,
                                              input logic       f7_5,
                                              input logic       reg_form);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (reg_form && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; rst is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no latch is
  // inferred on a path that forgets to assign it.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem.imem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_nxt = is_mem_access ? S_MEM : S_WB;
      S_MEM:    if (mem.dmem_ack) state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // State-dependent strobes and requests; everything is 0 in TRAP.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    pc_we        = 1'b0;
    rf_wr_en     = 1'b0;
    jump         = 1'b0;
    case (state)
      S_FETCH: mem.imem_req = 1'b1;
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = is_store;
      end
      S_WB: begin
        pc_we    = 1'b1;
        rf_wr_en = writes_rd && (rd_addr != 5'd0);
        jump     = is_jal | is_jalr | (is_branch & br_cond);
      end
      default: ;
    endcase
  end

  // Datapath steering, decoded purely from the instruction register.
  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b1;
    wb_sel    = WB_ALU;
    imm       = 32'd0;
    case (opcode)
      OPC_OP: begin
        alu_op    = funct_to_alu(funct3, funct7_5, 1'b1);
        alu_src_b = 1'b0;
      end
      OPC_OP_IMM: begin
        alu_op = funct_to_alu(funct3, funct7_5, 1'b0);
        imm    = {{20{ir[31]}}, ir[31:20]};
      end
      OPC_LOAD: begin
        wb_sel = WB_LOAD;
        imm    = {{20{ir[31]}}, ir[31:20]};
      end
      OPC_STORE: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH: begin
        alu_src_a = 1'b1;
        imm       = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OPC_JAL: begin
        alu_src_a = 1'b1;
        wb_sel    = WB_PC4;
        imm       = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      OPC_JALR: begin
        wb_sel = WB_PC4;
        imm    = {{20{ir[31]}}, ir[31:20]};
      end
      OPC_LUI: begin
        alu_op = ALU_PASSB;
        imm    = {ir[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        alu_src_a = 1'b1;
        imm       = {ir[31:12], 12'd0};
      end
      default: ;
    endcase
  end

  // Instruction register, retire counter and sticky trap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir      <= NOP;
      retired <= 32'd0;
      illegal <= 1'b0;
    end else begin
      if (state == S_FETCH && mem.imem_ack) ir <= mem.imem_rdata;
      if (state == S_WB) retired <= retired + 32'd1;
      if (state == S_DECODE && !legal) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_ctrl.sv
// Directed-vector bench for rv32i_ctrl: one task per scenario, each with
// hand-computed expectations checked inline.
module tb_rv32i_ctrl;

  logic        clk;
  logic        rst;
  logic        br_cond;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        alu_src_a, alu_src_b;
  logic [1:0]  wb_sel;
  logic        rf_wr_en, pc_we, jump, illegal;
  logic [31:0] retired;

  rv32i_ctrl_if bus ();

  rv32i_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (bus),
    .br_cond   (br_cond),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .imm       (imm),
    .alu_op    (alu_op),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .wb_sel    (wb_sel),
    .rf_wr_en  (rf_wr_en),
    .pc_we     (pc_we),
    .jump      (jump),
    .illegal   (illegal),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int exp_retired;

  // Snapshot of the write-back cycle of the last instruction run.
  int          cyc, dreq_cyc, pc_we_cnt, rf_cnt;
  logic        dwe_seen, s_rf, s_jump, s_a, s_b;
  logic [1:0]  s_sel;
  logic [3:0]  s_op;
  logic [31:0] s_imm;
  logic [4:0]  s_rd, s_rs1, s_rs2;

  // Runs one instruction from FETCH through WB, acting as both memories.
  // Entered and left at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] instr, input int iwait,
                           input int dwait, input logic br, input logic stray);
    int icnt = 0;
    int dcnt = 0;
    bit done = 0;
    cyc = 0; dreq_cyc = 0; dwe_seen = 1'bx; pc_we_cnt = 0; rf_cnt = 0;
    bus.imem_rdata = instr;
    br_cond = br;
    for (int i = 0; i < 60 && !done; i++) begin
      cyc++;
      if (bus.imem_req) begin bus.imem_ack = (icnt >= iwait); icnt++; end
      else bus.imem_ack = stray;
      if (bus.dmem_req) begin
        bus.dmem_ack = (dcnt >= dwait); dcnt++; dreq_cyc++; dwe_seen = bus.dmem_we;
      end else bus.dmem_ack = stray;
      if (rf_wr_en) rf_cnt++;
      if (pc_we) begin
        pc_we_cnt++; done = 1;
        s_rf = rf_wr_en; s_jump = jump; s_a = alu_src_a; s_b = alu_src_b;
        s_sel = wb_sel; s_op = alu_op; s_imm = imm;
        s_rd = rd_addr; s_rs1 = rs1_addr; s_rs2 = rs2_addr;
      end
      @(posedge clk); #1;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL wb_timeout: instr %08h got no pc_we within 60 cycles, want one", instr);
    end else exp_retired++;
    vectors++;
    if (pc_we !== 1'b0 || rf_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL strobe_width: instr %08h got pc_we=%b rf_wr_en=%b after WB, want 0/0", instr, pc_we, rf_wr_en);
    end
    vectors++;
    if (retired !== exp_retired) begin
      miscompares++;
      $display("FAIL retired: instr %08h got %0d, want %0d", instr, retired, exp_retired);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; br_cond = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_retired = 0;
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL reset_imem_req: got %b want 1", bus.imem_req); end
    vectors++; if ({bus.dmem_req, pc_we, rf_wr_en, jump} !== 4'b0) begin miscompares++; $display("FAIL reset_strobes: got %b want 0000", {bus.dmem_req, pc_we, rf_wr_en, jump}); end
    vectors++; if (retired !== 32'd0) begin miscompares++; $display("FAIL reset_retired: got %0d want 0", retired); end
    vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    // NOP in the instruction register decodes as ADDI x0,x0,0
    vectors++; if ({alu_op, alu_src_b, rd_addr} !== {4'd0, 1'b1, 5'd0} || imm !== 32'd0) begin miscompares++; $display("FAIL reset_nop_decode: got op=%0d b=%b rd=%0d imm=%h want 0/1/0/0", alu_op, alu_src_b, rd_addr, imm); end
  endtask

  task automatic test_addi;
    run_instr(32'h0070_0293, 0, 0, 1'b0, 1'b0);
    vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL addi_cycles: got %0d want 4", cyc); end
    vectors++; if (s_rf !== 1'b1 || s_rd !== 5'd5) begin miscompares++; $display("FAIL addi_wb: got rf=%b rd=%0d want 1/5", s_rf, s_rd); end
    vectors++; if (s_op !== 4'd0 || s_b !== 1'b1 || s_imm !== 32'd7 || s_jump !== 1'b0) begin miscompares++; $display("FAIL addi_ctrl: got op=%0d b=%b imm=%h jump=%b want 0/1/7/0", s_op, s_b, s_imm, s_jump); end
    vectors++; if (retired !== 32'd1) begin miscompares++; $display("FAIL addi_retired: got %0d want 1", retired); end
  endtask

  task automatic test_sw_lw;
    run_instr(32'h0050_2423, 0, 2, 1'b0, 1'b0);  // SW x5,8(x0)
    vectors++; if (dreq_cyc !== 3 || dwe_seen !== 1'b1) begin miscompares++; $display("FAIL sw_mem: got req_cycles=%0d we=%b want 3/1", dreq_cyc, dwe_seen); end
    vectors++; if (s_rf !== 1'b0 || rf_cnt !== 0 || s_imm !== 32'd8 || cyc !== 7) begin miscompares++; $display("FAIL sw_wb: got rf=%b rf_cnt=%0d imm=%h cyc=%0d want 0/0/8/7", s_rf, rf_cnt, s_imm, cyc); end
    run_instr(32'h0080_2303, 0, 2, 1'b0, 1'b0);  // LW x6,8(x0)
    vectors++; if (dreq_cyc !== 3 || dwe_seen !== 1'b0) begin miscompares++; $display("FAIL lw_mem: got req_cycles=%0d we=%b want 3/0", dreq_cyc, dwe_seen); end
    vectors++; if (s_sel !== 2'd1 || s_rf !== 1'b1 || s_rd !== 5'd6 || cyc !== 7) begin miscompares++; $display("FAIL lw_wb: got sel=%0d rf=%b rd=%0d cyc=%0d want 1/1/6/7", s_sel, s_rf, s_rd, cyc); end
  endtask

  task automatic test_branch;
    run_instr(32'hFE20_8CE3, 0, 0, 1'b1, 1'b0);  // BEQ x1,x2,-8 taken
    vectors++; if (s_jump !== 1'b1 || s_imm !== 32'hFFFF_FFF8 || s_a !== 1'b1) begin miscompares++; $display("FAIL beq_taken: got jump=%b imm=%h a=%b want 1/fffffff8/1", s_jump, s_imm, s_a); end
    vectors++; if (s_rs1 !== 5'd1 || s_rs2 !== 5'd2 || cyc !== 4) begin miscompares++; $display("FAIL beq_fields: got rs1=%0d rs2=%0d cyc=%0d want 1/2/4", s_rs1, s_rs2, cyc); end
    run_instr(32'hFE20_8CE3, 0, 0, 1'b0, 1'b0);  // not taken
    vectors++; if (s_jump !== 1'b0 || s_rf !== 1'b0) begin miscompares++; $display("FAIL beq_not_taken: got jump=%b rf=%b want 0/0", s_jump, s_rf); end
  endtask

  task automatic test_jal_jalr;
    run_instr(32'h0100_006F, 0, 0, 1'b0, 1'b0);  // JAL x0,+16
    vectors++; if (s_jump !== 1'b1 || s_sel !== 2'd2 || s_rf !== 1'b0 || rf_cnt !== 0) begin miscompares++; $display("FAIL jal_wb: got jump=%b sel=%0d rf=%b rf_cnt=%0d want 1/2/0/0", s_jump, s_sel, s_rf, rf_cnt); end
    vectors++; if (s_imm !== 32'd16 || s_a !== 1'b1) begin miscompares++; $display("FAIL jal_imm: got imm=%h a=%b want 10/1", s_imm, s_a); end
    run_instr(32'h0041_00E7, 0, 0, 1'b0, 1'b0);  // JALR x1,4(x2)
    vectors++; if (s_rf !== 1'b1 || s_a !== 1'b0 || s_jump !== 1'b1 || s_sel !== 2'd2) begin miscompares++; $display("FAIL jalr_wb: got rf=%b a=%b jump=%b sel=%0d want 1/0/1/2", s_rf, s_a, s_jump, s_sel); end
    vectors++; if (s_imm !== 32'd4 || s_rs1 !== 5'd2 || s_rd !== 5'd1) begin miscompares++; $display("FAIL jalr_fields: got imm=%h rs1=%0d rd=%0d want 4/2/1", s_imm, s_rs1, s_rd); end
  endtask

  task automatic test_alu_decode;
    run_instr(32'h4020_81B3, 0, 0, 1'b0, 1'b0);  // SUB x3,x1,x2
    vectors++; if (s_op !== 4'd1 || s_b !== 1'b0 || s_rf !== 1'b1 || s_rd !== 5'd3) begin miscompares++; $display("FAIL sub: got op=%0d b=%b rf=%b rd=%0d want 1/0/1/3", s_op, s_b, s_rf, s_rd); end
    run_instr(32'h4032_5213, 0, 0, 1'b0, 1'b0);  // SRAI x4,x4,3
    vectors++; if (s_op !== 4'd7 || s_b !== 1'b1 || s_imm !== 32'h0000_0403) begin miscompares++; $display("FAIL srai: got op=%0d b=%b imm=%h want 7/1/403", s_op, s_b, s_imm); end
    run_instr(32'hC000_0093, 0, 0, 1'b0, 1'b0);  // ADDI x1,x0,-1024 (bit30 set)
    vectors++; if (s_op !== 4'd0 || s_imm !== 32'hFFFF_FC00) begin miscompares++; $display("FAIL addi_neg: got op=%0d imm=%h want 0/fffffc00", s_op, s_imm); end
    run_instr(32'h1234_53B7, 0, 0, 1'b0, 1'b0);  // LUI x7,0x12345
    vectors++; if (s_op !== 4'd10 || s_imm !== 32'h1234_5000 || s_sel !== 2'd0 || s_rf !== 1'b1) begin miscompares++; $display("FAIL lui: got op=%0d imm=%h sel=%0d rf=%b want 10/12345000/0/1", s_op, s_imm, s_sel, s_rf); end
    run_instr(32'h0000_1417, 0, 0, 1'b0, 1'b0);  // AUIPC x8,1
    vectors++; if (s_op !== 4'd0 || s_a !== 1'b1 || s_imm !== 32'h0000_1000 || s_jump !== 1'b0) begin miscompares++; $display("FAIL auipc: got op=%0d a=%b imm=%h jump=%b want 0/1/1000/0", s_op, s_a, s_imm, s_jump); end
  endtask

  task automatic test_stray_acks;
    // Opposite-side acks held high whenever their request is low.
    run_instr(32'h0080_2303, 2, 1, 1'b0, 1'b1);
    vectors++; if (cyc !== 8 || dreq_cyc !== 2) begin miscompares++; $display("FAIL stray_lw: got cyc=%0d req_cycles=%0d want 8/2", cyc, dreq_cyc); end
    run_instr(32'h0070_0293, 1, 0, 1'b0, 1'b1);
    vectors++; if (cyc !== 5 || pc_we_cnt !== 1) begin miscompares++; $display("FAIL stray_addi: got cyc=%0d pc_we=%0d want 5/1", cyc, pc_we_cnt); end
  endtask

  task automatic test_illegal;
    int reqs = 0;
    int strobes = 0;
    bus.imem_rdata = 32'hFFFF_FFFF;
    bus.imem_ack = 1'b1;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    @(posedge clk); #1;
    vectors++; if (illegal !== 1'b1 || bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL trap_entry: got illegal=%b imem_req=%b want 1/0", illegal, bus.imem_req); end
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.imem_req) reqs++;
      if (bus.dmem_req | pc_we | rf_wr_en) strobes++;
    end
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    vectors++; if (reqs !== 0 || strobes !== 0 || illegal !== 1'b1) begin miscompares++; $display("FAIL trap_hold: got reqs=%0d strobes=%0d illegal=%b want 0/0/1", reqs, strobes, illegal); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_retired = 0;
    vectors++; if (illegal !== 1'b0 || bus.imem_req !== 1'b1 || retired !== 32'd0) begin miscompares++; $display("FAIL trap_reset: got illegal=%b imem_req=%b retired=%0d want 0/1/0", illegal, bus.imem_req, retired); end
  endtask

  task automatic test_mem_reset;
    bus.imem_rdata = 32'h0080_2303;
    bus.imem_ack = 1'b1;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    vectors++; if (bus.dmem_req !== 1'b1) begin miscompares++; $display("FAIL mem_reached: got dmem_req=%b want 1", bus.dmem_req); end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.dmem_req !== 1'b0 || pc_we !== 1'b0 || rf_wr_en !== 1'b0 || retired !== 32'd0) begin miscompares++; $display("FAIL mem_abort: got dmem_req=%b pc_we=%b rf=%b retired=%0d want 0/0/0/0", bus.dmem_req, pc_we, rf_wr_en, retired); end
    rst = 1'b0;
    exp_retired = 0;
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL mem_refetch: got imem_req=%b want 1", bus.imem_req); end
    run_instr(32'h0070_0293, 0, 0, 1'b0, 1'b0);
    vectors++; if (retired !== 32'd1 || cyc !== 4) begin miscompares++; $display("FAIL resume: got retired=%0d cyc=%0d want 1/4", retired, cyc); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_addi();
    test_sw_lw();
    test_branch();
    test_jal_jalr();
    test_alu_decode();
    test_stray_acks();
    test_illegal();
    test_mem_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
